uart_imem_loader: RTL
=====================

Name: uart_imem_loader

Overview:
- Upstream feeder of the pipelined CPU's instruction memory.
- Receives a program over a UART line (8N1), assembles big-endian 32-bit words and writes them into instruction memory through a write port.
- Holds the CPU in reset (CPU_HOLD) until a complete, checksum-valid image has been written.
- Lets new programs be loaded on the board without re-synthesis.

Parameters:
- CLKS_PER_BIT, 868, CLOCK cycles per UART bit (100 MHz / 115200); must be >= 4.
- IMEM_DEPTH, 64, number of 32-bit instruction words.
- ADDR_W, 6, word-address width; must satisfy 2^ADDR_W >= IMEM_DEPTH.

Ports:
- CLOCK  input  1  system clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- RXD  input  1  asynchronous UART receive line; idles high.
- IMEM_WE  output  1  one-cycle write strobe to instruction memory.
- IMEM_ADDR  output  ADDR_W  word index being written.
- IMEM_WDATA  output  32  assembled instruction word.
- CPU_HOLD  output  1  drive CPU RESET while high.
- LOAD_DONE  output  1  last load completed with a valid checksum.
- LOAD_ERR  output  1  last load aborted (framing, checksum, or timeout).

Behaviour:
- Reset values:
  - IMEM_WE=0, IMEM_ADDR=0, IMEM_WDATA=0.
  - CPU_HOLD=1, LOAD_DONE=0, LOAD_ERR=0.
  - Receiver idle, FSM in S_HDR.
- RXD synchronisation: through 2 flip-flops before any use.
- Receiver, per byte:
  - Start is detected on a synchronised high->low edge.
  - The start bit is re-checked at CLKS_PER_BIT/2. If it is high, treat it as a glitch: return to idle and produce no byte and no error.
  - Data bits are sampled every CLKS_PER_BIT after that, LSB first.
  - Stop bit sampled high: pulse byte_valid for one cycle with the byte.
  - Stop bit sampled low: pulse frame_err for one cycle.
- Frame protocol, in order:
  - Header 0xA5.
  - Count byte N; 0 means IMEM_DEPTH. Values > IMEM_DEPTH are clamped to IMEM_DEPTH.
  - N words, each 4 bytes MSB first.
  - Checksum byte = XOR of all 4N data bytes.
- FSM states: S_HDR, S_CNT, S_DATA, S_CSUM, S_DONE, S_ERR.
  - S_HDR: 0xA5 -> S_CNT. Any other byte is ignored and flags are unchanged.
  - S_CNT: latch N; clear word index, byte index and running XOR; set CPU_HOLD=1, LOAD_DONE=0, LOAD_ERR=0; -> S_DATA.
  - S_DATA: shift each byte into the word register and fold it into the XOR.
    - On the 4th byte, the next cycle drives IMEM_WE=1 for exactly one cycle, with IMEM_ADDR = word index and IMEM_WDATA = the word.
    - The word index then increments. When it reaches N -> S_CSUM.
  - S_CSUM: byte == XOR -> S_DONE, setting LOAD_DONE=1 and CPU_HOLD=0 on the cycle after byte_valid. Mismatch -> S_ERR, setting LOAD_ERR=1; CPU_HOLD stays 1.
  - S_DONE / S_ERR: behave as S_HDR. A new 0xA5 starts a new load; CPU_HOLD rises in the cycle S_CNT is entered.
  - frame_err in any state other than S_HDR, S_DONE or S_ERR -> S_ERR, LOAD_ERR=1, CPU_HOLD=1. In those three states frame_err is ignored.
- Boundary conditions:
  - Words already written before an error remain in memory.
  - IMEM_ADDR never exceeds IMEM_DEPTH-1.
  - byte_valid and frame_err are mutually exclusive by construction.
  - RESET mid-byte or mid-load discards everything and returns to reset values; no IMEM_WE is issued in the reset cycle.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - In S_CNT, S_DATA and S_CSUM, a counter measures idle time since the last byte_valid.
  - Reaching 32*CLKS_PER_BIT cycles -> S_ERR, LOAD_ERR=1, CPU_HOLD=1.
  - The counter clears on every byte_valid and on state entry.
- Undefined: no timeout; the FSM waits indefinitely.

Decomposition:
- Package loader_pkg holds:
  - the state enum;
  - HDR_BYTE=8'hA5;
  - TIMEOUT_BITS=32.
- Sub-module uart_rx_core (CLOCK, RESET, RXD -> byte_valid, byte_data[7:0], frame_err) contains the synchroniser, bit timer and shift register.
- The top level contains the protocol FSM, word assembly and XOR.

Test Plan (CLKS_PER_BIT=4, IMEM_DEPTH=8):
- Reset, no traffic -> CPU_HOLD=1, LOAD_DONE=0, LOAD_ERR=0, IMEM_WE never asserted.
- Send A5,02,20,08,00,05,00,00,00,00,checksum 0x2D:
  - IMEM_WE twice: addr0=0x20080005, addr1=0x00000000.
  - LOAD_DONE=1; CPU_HOLD falls one cycle after the checksum byte_valid.
- Same frame with checksum 0x2C -> both writes occur, then LOAD_ERR=1, CPU_HOLD=1, LOAD_DONE=0.
- Bytes 0x11,0x7E before A5, and a 1-cycle low glitch on RXD -> ignored; the subsequent valid load succeeds.
- Stop bit forced low on the 3rd data byte -> LOAD_ERR=1, one write fewer, FSM accepts a new A5.
- Count byte 0x00 with 32 data bytes -> 8 writes to addr 0..7, then checksum accepted.
- With LOADER_TIMEOUT_EN: stall 200 cycles after 2 data bytes -> LOAD_ERR=1.
- Without LOADER_TIMEOUT_EN: the same stall leaves the FSM still in S_DATA, and the load completes when the remaining bytes arrive.

Source files
------------

// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Optional build macro used by the loader: LOADER_TIMEOUT_EN.
package loader_pkg;

  typedef enum logic [2:0] {
    S_HDR,
    S_CNT,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0]  HDR_BYTE     = 8'hA5;
  localparam int unsigned TIMEOUT_BITS = 32;

  // Count byte to word count: 0 selects a full image, oversize counts saturate.
  function automatic logic [8:0] clamp_count(input logic [7:0] c, input int unsigned depth);
    if (c == 8'd0 || 32'(c) > depth) return 9'(depth);
    return {1'b0, c};
  endfunction

endpackage

// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port driven by the loader.
interface uart_imem_loader_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              IMEM_WE;
  logic [ADDR_W-1:0] IMEM_ADDR;
  logic [31:0]       IMEM_WDATA;

  modport master (output IMEM_WE, IMEM_ADDR, IMEM_WDATA);
  modport slave  (input  IMEM_WE, IMEM_ADDR, IMEM_WDATA);
endinterface

// File: rtl/uart_imem_loader_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, bit timer, LSB-first shift register.
module uart_rx_core
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       RXD,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned    CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rxd_meta;
  logic             rxd_sync;
  logic             rxd_prev;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  // Synchronise the asynchronous line and keep one older sample for edge detection.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Bit-timing state machine producing one-cycle byte/framing-error pulses.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rxd_prev && !rxd_sync) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxd_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rxd_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// UART program loader: parses A5 / count / words / XOR frames into instruction memory
// and holds the CPU in reset until a checksum-valid image is in place.
// Optional build macro: LOADER_TIMEOUT_EN (abort a stalled load after 32 idle bit times).
module uart_imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned IMEM_DEPTH   = 64,
  parameter int unsigned ADDR_W       = 6
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                RXD,
  uart_imem_loader_if.master  imem,
  output logic                CPU_HOLD,
  output logic                LOAD_DONE,
  output logic                LOAD_ERR
);

  logic       byte_valid;
  logic       frame_err;
  logic [7:0] byte_data;

  state_t     state;
  logic [8:0] word_cnt;
  logic [8:0] word_idx;
  logic [1:0] byte_idx;
  logic [23:0] word_hi;
  logic [7:0] csum;
  logic       active;
  logic       timeout;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .RXD        (RXD),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // States in which a load is in progress and line errors abort it.
  always_comb begin
    active = (state == S_CNT) || (state == S_DATA) || (state == S_CSUM);
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

  logic [TO_W-1:0] idle_cnt;

  // Idle time since the last byte; held at zero outside an active load.
  always_ff @(posedge CLOCK) begin
    if (RESET || byte_valid || !active) idle_cnt <= '0;
    else if (!timeout)                  idle_cnt <= idle_cnt + TO_W'(1);
  end

  // A byte arriving on the final idle cycle still wins over the timeout.
  always_comb begin
    timeout = active && !byte_valid && (idle_cnt == TO_W'(TO_LIMIT - 1));
  end
`else
  // Without the watchdog a load waits indefinitely for its next byte.
  always_comb begin
    timeout = 1'b0;
  end
`endif

  // Frame protocol FSM with word assembly, running XOR and registered outputs.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state           <= S_HDR;
      imem.IMEM_WE    <= 1'b0;
      imem.IMEM_ADDR  <= '0;
      imem.IMEM_WDATA <= '0;
      CPU_HOLD        <= 1'b1;
      LOAD_DONE       <= 1'b0;
      LOAD_ERR        <= 1'b0;
      word_cnt        <= '0;
      word_idx        <= '0;
      byte_idx        <= '0;
      word_hi         <= '0;
      csum            <= '0;
    end else begin
      imem.IMEM_WE <= 1'b0;
      if (active && (frame_err || timeout)) begin
        state     <= S_ERR;
        LOAD_ERR  <= 1'b1;
        LOAD_DONE <= 1'b0;
        CPU_HOLD  <= 1'b1;
      end else if (byte_valid) begin
        case (state)
          S_HDR, S_DONE, S_ERR: begin
            if (byte_data == HDR_BYTE) begin
              state    <= S_CNT;
              CPU_HOLD <= 1'b1;
            end
          end
          S_CNT: begin
            word_cnt  <= clamp_count(byte_data, IMEM_DEPTH);
            word_idx  <= '0;
            byte_idx  <= '0;
            csum      <= '0;
            CPU_HOLD  <= 1'b1;
            LOAD_DONE <= 1'b0;
            LOAD_ERR  <= 1'b0;
            state     <= S_DATA;
          end
          S_DATA: begin
            csum     <= csum ^ byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem.IMEM_WE    <= 1'b1;
              imem.IMEM_ADDR  <= ADDR_W'(word_idx);
              imem.IMEM_WDATA <= {word_hi, byte_data};
              word_idx        <= word_idx + 9'd1;
              if (word_idx + 9'd1 == word_cnt) state <= S_CSUM;
            end else begin
              word_hi <= {word_hi[15:0], byte_data};
            end
          end
          S_CSUM: begin
            if (byte_data == csum) begin
              state     <= S_DONE;
              LOAD_DONE <= 1'b1;
              CPU_HOLD  <= 1'b0;
            end else begin
              state     <= S_ERR;
              LOAD_ERR  <= 1'b1;
              LOAD_DONE <= 1'b0;
              CPU_HOLD  <= 1'b1;
            end
          end
          default: state <= S_HDR;
        endcase
      end
    end
  end

endmodule
